idu: RTL
========

# idu

Instruction decode unit for the NPC core, sitting between the IFU and the ALU. Accepts one fetched instruction per transaction and reads the register file. It drives the ALU's `alu_ctrl`, `src1`, `src2`, `csr_input` and `instruction` inputs together with `idu_done`, then holds them until the ALU answers with `alu_done`. It is the initiating end of the `idu_done`/`alu_done` handshake.

## Interface
- Parameters: none.
- `clk` in 1: core clock, all state on posedge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `ifu_valid` in 1: `ifu_inst`/`ifu_pc` valid.
- `ifu_inst` in 32: fetched instruction.
- `ifu_pc` in 32: its PC.
- `idu_ready` out 1: IDU can accept; high only in IDLE.
- `rs1_addr` out 5: regfile read address, equals `inst_q[19:15]`.
- `rs2_addr` out 5: regfile read address, equals `inst_q[24:20]`.
- `rs1_data` in 32: combinational regfile read data.
- `rs2_data` in 32: combinational regfile read data.
- `csr_rdata` in 32: CSR value addressed by `csr_addr`.
- `csr_addr` out 12: `inst_q[31:20]`.
- `instruction` out 32: latched instruction `inst_q`.
- `alu_ctrl` out 5: ALU operation code.
- `src1` out 32: ALU operand 1.
- `src2` out 32: ALU operand 2.
- `csr_input` out 32: registered `csr_rdata`.
- `imm` out 32: sign-extended immediate.
- `link_addr` out 32: PC + 4.
- `rd` out 5: destination register.
- `rf_wen` out 1: destination register is written.
- `is_branch` out 1: decoded class flag.
- `is_jump` out 1: decoded class flag.
- `is_load` out 1: decoded class flag.
- `is_store` out 1: decoded class flag.
- `is_csr` out 1: decoded class flag.
- `illegal` out 1: undecodable opcode seen.
- `idu_done` out 1: decode outputs valid, ALU may execute.
- `alu_done` in 1: ALU completion.

## Operation
FSM states and transitions:
- IDLE: `idu_ready=1`. If `ifu_valid` is high at a posedge, latch `ifu_inst` into `inst_q` and `ifu_pc` into `pc_q`, then go to DECODE.
- DECODE: exactly one cycle. Decode `inst_q`, sample `rs*_data` and `csr_rdata`, and register every decode output. Then go to ISSUE, or to HALT if the instruction is illegal and the trap is enabled.
- ISSUE: `idu_done=1`. All outputs are held stable; `ifu_valid` is ignored. On a posedge where `alu_done=1`, go to IDLE.
- HALT: `illegal=1`, `idu_ready=0`, `idu_done=0`. Sticky until reset.

`alu_ctrl` encoding, with default operands `src1=rs1_data`, `src2=rs2_data` (R-type) or `imm` (I-type):
- add/addi/load/store address: 00000.
- sub: 00010.
- sltu/sltiu: 00100.
- xor: 00101.
- or: 00110.
- and: 00111.
- sll: 01000.
- sra: 01001.
- srl: 01010.
- slt/slti: 01100.
- slli: 10011.
- srai: 10100.
- srli: 10101.
- lui: 00001, with `src2=immU`.
- auipc: 00000, with `src1=pc_q`, `src2=immU`.
- jal: 00000, with `src1=pc_q`, `src2=immJ`.
- jalr: 00011, with `src2=immI`.
- Branches: beq 01101, bne 10010, blt 10000, bge 01110, bltu 10001, bgeu 01111; `src2=rs2_data`, `imm=immB`.
- csrrs: 10110. csrrw: 10111.

Flag and immediate rules:
- `rf_wen=1` for R, I-ALU, load, lui, auipc, jal, jalr and csr instructions, and only if `rd!=0`. Otherwise 0.
- Immediates are sign-extended from bit 31; immU has its low 12 bits zero.
- Shift amount is `inst_q[24:20]`.
- `link_addr = pc_q + 32'd4`, modulo 2^32 (0xFFFFFFFC wraps to 0).

## Timing
- Reset values of all outputs are 0, except `idu_ready=1`. State resets to IDLE. Reset asserted in any state, including mid-ISSUE, takes effect immediately.
- Latency: accept at edge N, outputs registered at edge N+1, `idu_done=1` from N+1 to the edge after `alu_done` is sampled high.
- `alu_done` arriving in the same cycle `idu_done` first rises completes the transaction at the next edge. Minimum transaction is 3 cycles.
- `alu_done` seen while not in ISSUE is ignored.
- Acceptance needs `ifu_valid` in IDLE only; there is no accept on the cycle `idu_done` falls.

## Configuration
- `IDU_ILLEGAL_TRAP_EN` defined:
  - An unknown opcode, or unknown funct3/funct7, sets `illegal=1` and enters HALT; `idu_done` is never asserted.
- Undefined:
  - The instruction decodes as `alu_ctrl=00000`, `rf_wen=0` with all class flags 0, then issues normally.
  - `illegal` is tied to 0.

## Test plan
- Reset and abort: pulse `rst_n` low mid-ISSUE -> same cycle `idu_done=0`, `idu_ready=1`, `alu_ctrl=0`.
- addi: 0xFFB10093 (addi x1,x2,-5) with `rs1_data=10`, `alu_done=1` immediately -> `rs1_addr=2`, `src1=10`, `src2=0xFFFFFFFB`, `alu_ctrl=00000`, `rd=1`, `rf_wen=1`, `idu_done` high 1 cycle.
- bne: 0xFE419CE3 (bne x3,x4,-8) -> `alu_ctrl=10010`, `imm=0xFFFFFFF8`, `is_branch=1`, `rf_wen=0`.
- Stall: 0x123452B7 (lui x5,0x12345) with `alu_done` held 0 for 5 cycles -> `idu_done=1`, `src2=0x12345000`, `alu_ctrl=00001` stable, `idu_ready=0`, `ifu_valid` pulses ignored.
- Wrap: `ifu_pc=0xFFFFFFFC` with jal -> `link_addr=0`.
- Illegal: 0x00000000 -> with macro, `illegal=1` and HALT until reset; without macro, `alu_ctrl=0`, `rf_wen=0`, `idu_done` asserted.

Source files
------------

// File: rtl/idu.sv
// Instruction decode unit: latches one IFU instruction, decodes it in one cycle and
// holds registered operands on idu_done until alu_done. Optional macro IDU_ILLEGAL_TRAP_EN.
module idu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ifu_valid,
  input  logic [31:0] ifu_inst,
  input  logic [31:0] ifu_pc,
  output logic        idu_ready,
  output logic [4:0]  rs1_addr,
  output logic [4:0]  rs2_addr,
  input  logic [31:0] rs1_data,
  input  logic [31:0] rs2_data,
  input  logic [31:0] csr_rdata,
  output logic [11:0] csr_addr,
  output logic [31:0] instruction,
  output logic [4:0]  alu_ctrl,
  output logic [31:0] src1,
  output logic [31:0] src2,
  output logic [31:0] csr_input,
  output logic [31:0] imm,
  output logic [31:0] link_addr,
  output logic [4:0]  rd,
  output logic        rf_wen,
  output logic        is_branch,
  output logic        is_jump,
  output logic        is_load,
  output logic        is_store,
  output logic        is_csr,
  output logic        illegal,
  output logic        idu_done,
  input  logic        alu_done,
  output logic [1:0]  dbg_state
);

  // Handshake: idu_ready accepts ifu_valid at a posedge in IDLE; idu_done holds all
  // decode outputs stable until a posedge samples alu_done high.
  typedef enum logic [1:0] {IDLE = 2'd0, DECODE = 2'd1, ISSUE = 2'd2, HALT = 2'd3} state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  state_t      state_q, state_d;
  logic [31:0] inst_q, pc_q;
  logic [4:0]  alu_ctrl_q, rd_q;
  logic [31:0] src1_q, src2_q, imm_q, csr_input_q, link_addr_q;
  logic        rf_wen_q, is_branch_q, is_jump_q, is_load_q, is_store_q, is_csr_q;

  logic [4:0]  d_alu;
  logic [31:0] d_src1, d_src2, d_imm;
  logic        d_wr, d_br, d_jmp, d_ld, d_st, d_csr, d_bad;
  logic [2:0]  f3;
  logic        f7_zero, f7_alt;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, shamt;

  assign f3      = inst_q[14:12];
  assign f7_zero = (inst_q[31:25] == 7'h00);
  assign f7_alt  = (inst_q[31:25] == 7'h20);
  assign imm_i   = {{20{inst_q[31]}}, inst_q[31:20]};
  assign imm_s   = {{20{inst_q[31]}}, inst_q[31:25], inst_q[11:7]};
  assign imm_b   = {{19{inst_q[31]}}, inst_q[31], inst_q[7], inst_q[30:25], inst_q[11:8], 1'b0};
  assign imm_u   = {inst_q[31:12], 12'b0};
  assign imm_j   = {{11{inst_q[31]}}, inst_q[31], inst_q[19:12], inst_q[20], inst_q[30:21], 1'b0};
  assign shamt   = {27'b0, inst_q[24:20]};

  always_comb begin
    d_alu  = 5'b00000;
    d_src1 = rs1_data;
    d_src2 = rs2_data;
    d_imm  = 32'b0;
    d_wr   = 1'b0;
    d_br   = 1'b0;
    d_jmp  = 1'b0;
    d_ld   = 1'b0;
    d_st   = 1'b0;
    d_csr  = 1'b0;
    d_bad  = 1'b0;
    case (inst_q[6:0])
      OP_R: begin
        d_wr = 1'b1;
        case (f3)
          3'b000: begin d_alu = f7_alt ? 5'b00010 : 5'b00000; d_bad = !(f7_zero || f7_alt); end
          3'b001: begin d_alu = 5'b01000; d_bad = !f7_zero; end
          3'b010: begin d_alu = 5'b01100; d_bad = !f7_zero; end
          3'b011: begin d_alu = 5'b00100; d_bad = !f7_zero; end
          3'b100: begin d_alu = 5'b00101; d_bad = !f7_zero; end
          3'b101: begin d_alu = f7_alt ? 5'b01001 : 5'b01010; d_bad = !(f7_zero || f7_alt); end
          3'b110: begin d_alu = 5'b00110; d_bad = !f7_zero; end
          default: begin d_alu = 5'b00111; d_bad = !f7_zero; end
        endcase
      end
      OP_I: begin
        d_wr   = 1'b1;
        d_src2 = imm_i;
        d_imm  = imm_i;
        case (f3)
          3'b000: d_alu = 5'b00000;
          3'b010: d_alu = 5'b01100;
          3'b011: d_alu = 5'b00100;
          3'b100: d_alu = 5'b00101;
          3'b110: d_alu = 5'b00110;
          3'b111: d_alu = 5'b00111;
          3'b001: begin d_alu = 5'b10011; d_src2 = shamt; d_bad = !f7_zero; end
          default: begin
            d_alu  = f7_alt ? 5'b10100 : 5'b10101;
            d_src2 = shamt;
            d_bad  = !(f7_zero || f7_alt);
          end
        endcase
      end
      OP_LOAD: begin
        d_wr = 1'b1; d_ld = 1'b1; d_src2 = imm_i; d_imm = imm_i;
        d_bad = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
      end
      OP_STORE: begin
        d_st = 1'b1; d_src2 = imm_s; d_imm = imm_s;
        d_bad = f3[2] || (f3 == 3'b011);
      end
      OP_LUI:   begin d_wr = 1'b1; d_alu = 5'b00001; d_src2 = imm_u; d_imm = imm_u; end
      OP_AUIPC: begin d_wr = 1'b1; d_src1 = pc_q; d_src2 = imm_u; d_imm = imm_u; end
      OP_JAL:   begin d_wr = 1'b1; d_jmp = 1'b1; d_src1 = pc_q; d_src2 = imm_j; d_imm = imm_j; end
      OP_JALR: begin
        d_wr = 1'b1; d_jmp = 1'b1; d_alu = 5'b00011; d_src2 = imm_i; d_imm = imm_i;
        d_bad = (f3 != 3'b000);
      end
      OP_BRANCH: begin
        d_br  = 1'b1;
        d_imm = imm_b;
        case (f3)
          3'b000: d_alu = 5'b01101;
          3'b001: d_alu = 5'b10010;
          3'b100: d_alu = 5'b10000;
          3'b101: d_alu = 5'b01110;
          3'b110: d_alu = 5'b10001;
          3'b111: d_alu = 5'b01111;
          default: d_bad = 1'b1;
        endcase
      end
      OP_SYSTEM: begin
        d_wr = 1'b1; d_csr = 1'b1; d_src2 = csr_rdata; d_imm = imm_i;
        case (f3)
          3'b010: d_alu = 5'b10110;
          3'b001: d_alu = 5'b10111;
          default: d_bad = 1'b1;
        endcase
      end
      default: d_bad = 1'b1;
    endcase
    // An undecodable instruction degrades to a harmless non-writing add.
    if (d_bad) begin
      d_alu  = 5'b00000;
      d_src1 = rs1_data;
      d_src2 = rs2_data;
      d_imm  = 32'b0;
      d_wr   = 1'b0;
      d_br   = 1'b0;
      d_jmp  = 1'b0;
      d_ld   = 1'b0;
      d_st   = 1'b0;
      d_csr  = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (ifu_valid) state_d = DECODE;
`ifdef IDU_ILLEGAL_TRAP_EN
      DECODE: state_d = d_bad ? HALT : ISSUE;
`else
      DECODE: state_d = ISSUE;
`endif
      ISSUE:  if (alu_done) state_d = IDLE;
      default: state_d = HALT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst_q      <= 32'b0;
      pc_q        <= 32'b0;
      alu_ctrl_q  <= 5'b0;
      src1_q      <= 32'b0;
      src2_q      <= 32'b0;
      imm_q       <= 32'b0;
      csr_input_q <= 32'b0;
      link_addr_q <= 32'b0;
      rd_q        <= 5'b0;
      rf_wen_q    <= 1'b0;
      is_branch_q <= 1'b0;
      is_jump_q   <= 1'b0;
      is_load_q   <= 1'b0;
      is_store_q  <= 1'b0;
      is_csr_q    <= 1'b0;
    end else if (state_q == IDLE) begin
      if (ifu_valid) begin
        inst_q <= ifu_inst;
        pc_q   <= ifu_pc;
      end
    end else if (state_q == DECODE) begin
      alu_ctrl_q  <= d_alu;
      src1_q      <= d_src1;
      src2_q      <= d_src2;
      imm_q       <= d_imm;
      csr_input_q <= csr_rdata;
      link_addr_q <= pc_q + 32'd4;
      rd_q        <= d_wr ? inst_q[11:7] : 5'b0;
      rf_wen_q    <= d_wr && (inst_q[11:7] != 5'b0);
      is_branch_q <= d_br;
      is_jump_q   <= d_jmp;
      is_load_q   <= d_ld;
      is_store_q  <= d_st;
      is_csr_q    <= d_csr;
    end
  end

`ifdef IDU_ILLEGAL_TRAP_EN
  logic illegal_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 illegal_q <= 1'b0;
    else if (state_q == DECODE) illegal_q <= d_bad;
  end
  assign illegal = illegal_q;
`else
  assign illegal = 1'b0;
`endif

  assign idu_ready   = (state_q == IDLE);
  assign idu_done    = (state_q == ISSUE);
  assign dbg_state   = state_q;
  assign rs1_addr    = inst_q[19:15];
  assign rs2_addr    = inst_q[24:20];
  assign csr_addr    = inst_q[31:20];
  assign instruction = inst_q;
  assign alu_ctrl    = alu_ctrl_q;
  assign src1        = src1_q;
  assign src2        = src2_q;
  assign imm         = imm_q;
  assign csr_input   = csr_input_q;
  assign link_addr   = link_addr_q;
  assign rd          = rd_q;
  assign rf_wen      = rf_wen_q;
  assign is_branch   = is_branch_q;
  assign is_jump     = is_jump_q;
  assign is_load     = is_load_q;
  assign is_store    = is_store_q;
  assign is_csr      = is_csr_q;

endmodule
